// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//
// Instruction-fetch stage for the single-cycle load/store datapath. Holds the
// program counter and a writable instruction memory. It issues one registered
// 32-bit instruction per issue slot, either every cycle (free-run) or once per
// rising edge of the step button (single-step).
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous, active-low reset
//   run             level, 1 = free-run mode
//   step            single-step request, acts on its rising edge only
//   stall           downstream cannot accept, so outputs hold
//   redirect        branch taken / jump this cycle
//   redirect_target byte address for the redirect (low two bits dropped)
//   prog_we         instruction memory write enable (honoured in IDLE only)
//   prog_addr       word address for program load
//   prog_data       instruction word to load
//   inst            issued instruction (0 = NOP when not valid)
//   inst_valid      inst is a new instruction this cycle
//   pc              byte address of inst
//   halted          fetch stopped (HALT_OP word or out-of-range address)
//   state_dbg       FSM state: 0 = IDLE, 1 = RUN, 2 = HALT
//
// Handshake: inst_valid marks a new instruction on inst/pc. stall acts as
// the inverse of ready. While stall is high (and no redirect is present),
// inst, inst_valid, pc and the fetch address hold. This lets a valid
// instruction stay presented until the datapath takes it. A redirect always
// wins and flushes the output to a NOP.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     step,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_target,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic [31:0]              inst,
    output logic                     inst_valid,
    output logic [31:0]              pc,
    output logic                     halted,
    output logic [1:0]               state_dbg
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    mem [DEPTH];
    logic [31:0]    fetch_pc;
    logic           step_q;
    logic           step_edge;
    logic [AW-1:0]  fetch_idx;
    logic [31:0]    fetch_word;
    logic           out_of_range;
    logic           issue;
    logic           halt_hit;
    logic           unused_bits;

    // The redirect target is word-aligned by dropping its low bits.
    assign unused_bits = ^redirect_target[1:0];

    assign fetch_idx    = fetch_pc[AW+1:2];
    // DEPTH is a power of two, so any set bit above the index field means
    // the word address is >= DEPTH.
    assign out_of_range = |fetch_pc[31:AW+2];
    assign halted       = (state == S_HALT);
    assign state_dbg    = state;

    always_comb begin
        step_edge  = step & ~step_q;
        // Combinational read of the pre-edge contents: a same-cycle program
        // write to the fetched word returns the old word.
        fetch_word = mem[fetch_idx];
        issue      = ((state == S_RUN) || ((state == S_IDLE) && step_edge)) &&
                     !stall && !redirect;
        halt_hit   = issue && ((fetch_word[31:26] == HALT_OP) || out_of_range);

        state_next = state;
        case (state)
            S_IDLE:  if (run)  state_next = S_RUN;
            S_RUN:   if (!run) state_next = S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        if (halt_hit) begin
            state_next = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            pc         <= 32'h0;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            step_q <= step;
            if (state == S_HALT) begin
                inst       <= 32'h0;
                inst_valid <= 1'b0;
            end else if (redirect) begin
                fetch_pc   <= {redirect_target[31:2], 2'b00};
                inst       <= 32'h0;
                inst_valid <= 1'b0;
            end else if (stall) begin
                // Hold everything; a step edge seen now is dropped.
            end else if (issue && !halt_hit) begin
                inst       <= fetch_word;
                pc         <= fetch_pc;
                inst_valid <= 1'b1;
                fetch_pc   <= fetch_pc + 32'd4;
            end else begin
                // Idle slot, or the HALT word / bad address was reached:
                // present a NOP and leave fetch_pc where it is.
                inst       <= 32'h0;
                inst_valid <= 1'b0;
            end
        end
    end

    // Memory has no reset so a program survives a reset. Loading is only
    // allowed while the fetcher is parked in IDLE.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          DEPTH     = 64;
  localparam int          AW        = 6;
  localparam logic [5:0]  HALT_OP   = 6'b111111;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam int          MODE_IDLE = 0;
  localparam int          MODE_RUN  = 1;
  localparam int          MODE_HALT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_target = 32'h0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = 32'h0;
  logic [31:0]   inst;
  logic          inst_valid;
  logic [31:0]   pc;
  logic          halted;
  logic [1:0]    state_dbg;

  instr_fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000),
    .HALT_OP(HALT_OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .step(step),
    .stall(stall),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .inst(inst),
    .inst_valid(inst_valid),
    .pc(pc),
    .halted(halted),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the program image, the next fetch byte address and the operating
  // mode; computes what the outputs must be after each clock edge.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_prev_step = 1'b0;
  int          m_mode = MODE_IDLE;

  task automatic model_edge(input logic r, input logic ru, input logic st, input logic sl,
                            input logic rd, input logic [31:0] tg, input logic we,
                            input logic [AW-1:0] ad, input logic [31:0] dt);
    logic        pressed;
    logic        wr_ok;
    logic [31:0] word;
    wr_ok = we && (m_mode == MODE_IDLE);
    if (!r) begin
      m_addr = 32'h0; m_pc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
      m_mode = MODE_IDLE; m_prev_step = 1'b0;
    end else begin
      pressed = st && !m_prev_step;
      m_prev_step = st;
      if (m_mode == MODE_HALT) begin
        m_inst = 32'h0; m_valid = 1'b0;
      end else begin
        if (rd) begin
          m_addr = tg & 32'hFFFF_FFFC;
          m_inst = 32'h0; m_valid = 1'b0;
        end else if (!sl) begin
          if (m_mode == MODE_RUN || pressed) begin
            if ((m_addr >> 2) >= 32'(DEPTH)) begin
              m_mode = MODE_HALT; m_inst = 32'h0; m_valid = 1'b0;
            end else begin
              word = m_mem[m_addr[AW+1:2]];
              if (word[31:26] == HALT_OP) begin
                m_mode = MODE_HALT; m_inst = 32'h0; m_valid = 1'b0;
              end else begin
                m_inst = word; m_pc = m_addr; m_valid = 1'b1; m_addr = m_addr + 32'd4;
              end
            end
          end else begin
            m_inst = 32'h0; m_valid = 1'b0;
          end
        end
        if (m_mode != MODE_HALT) m_mode = ru ? MODE_RUN : MODE_IDLE;
      end
    end
    // Write lands after the fetch read, so a same-word fetch sees old data.
    if (wr_ok) m_mem[ad] = dt;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic ru, input logic st, input logic sl,
                       input logic rd, input logic [31:0] tg, input logic we,
                       input logic [AW-1:0] ad, input logic [31:0] dt);
    rst = r; run = ru; step = st; stall = sl; redirect = rd; redirect_target = tg;
    prog_we = we; prog_addr = ad; prog_data = dt;
    @(posedge clk);
    model_edge(r, ru, st, sl, rd, tg, we, ad, dt);
    #1;
    check("model.inst", inst, m_inst);
    check("model.inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    check("model.pc", pc, m_pc);
    check("model.halted", {31'b0, halted}, {31'b0, m_mode == MODE_HALT});
    check("model.state", {30'b0, state_dbg}, 32'(m_mode));
  endtask

  task automatic tick(input logic ru, input logic st, input logic sl, input logic rd,
                      input logic [31:0] tg);
    drive(1'b1, ru, st, sl, rd, tg, 1'b0, '0, 32'h0);
  endtask

  task automatic do_reset(input logic ru);
    drive(1'b0, ru, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r, ru, st, sl, rd;
    logic [31:0]   tg;
    logic          we;
    logic [AW-1:0] ad;
    logic [31:0]   dt;
    logic [31:0]   e_inst;
    logic          e_valid;
    logic [31:0]   e_pc;
    logic          e_halted;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int pulses;
    logic [31:0] pulse_pc;
    logic [31:0] pulse_inst;

    // ---- table: program load, free run to HALT, write lock, reset ----
    //            r  ru st sl rd tg      we ad   dt            e_inst        v  e_pc   h
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h0,        0, 32'h0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 32'h0, 1, 6'd0, 32'h5400_0005, 32'h0,       0, 32'h0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 32'h0, 1, 6'd1, 32'h5006_0002, 32'h0,       0, 32'h0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 32'h0, 1, 6'd2, 32'h0,        32'h0,        0, 32'h0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 32'h0, 1, 6'd3, HALT_WORD,    32'h0,        0, 32'h0, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h0,        0, 32'h0, 0};
    vecs[6]  = '{1, 1, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h5400_0005, 1, 32'h0, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h5006_0002, 1, 32'h4, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h0,        1, 32'h8, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h0,        0, 32'h8, 1};
    vecs[10] = '{1, 1, 0, 0, 0, 32'h0, 1, 6'd0, 32'hDEAD_BEEF, 32'h0,       0, 32'h8, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0, 0, 6'd0, 32'h0,        32'h0,        0, 32'h0, 0};

    // Power-up reset, then fill the whole memory with non-halt words.
    do_reset(1'b0);
    check("reset.state", {30'b0, state_dbg}, 32'd0);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, AW'(i), 32'h2000_0000 + 32'(i));

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].ru, vecs[i].st, vecs[i].sl, vecs[i].rd, vecs[i].tg,
            vecs[i].we, vecs[i].ad, vecs[i].dt);
      check($sformatf("vec%0d.inst", i), inst, vecs[i].e_inst);
      check($sformatf("vec%0d.valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d.halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
    end

    // ---- single-step: step held 10 cycles gives one pulse ----
    pulses = 0; pulse_pc = 32'hFFFF_FFFF; pulse_inst = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (inst_valid) begin pulses++; pulse_pc = pc; pulse_inst = inst; end
    end
    check("step.pulses", 32'(pulses), 32'd1);
    check("step.pc", pulse_pc, 32'h0);
    check("step.inst_kept", pulse_inst, 32'h5400_0005);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("step2.valid", {31'b0, inst_valid}, 32'd1);
    check("step2.pc", pc, 32'h4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // ---- stall in RUN at pc=4 ----
    do_reset(1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("prestall.pc", pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check("stall.valid", {31'b0, inst_valid}, 32'd1);
      check("stall.pc", pc, 32'h4);
      check("stall.inst", inst, 32'h5006_0002);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("unstall.pc", pc, 32'h8);
    check("unstall.valid", {31'b0, inst_valid}, 32'd1);

    // ---- redirect (with a locked-out write of HALT to the target word) ----
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b1, 6'd4, HALT_WORD);
    check("redir.bubble", {31'b0, inst_valid}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("redir.valid", {31'b0, inst_valid}, 32'd1);
    check("redir.pc", pc, 32'h10);
    check("redir.inst_lock", inst, 32'h2000_0004);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    check("redir_stall.flush", {31'b0, inst_valid}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("redir_stall.pc", pc, 32'h0);
    check("redir_stall.inst", inst, 32'h5400_0005);

    // ---- out-of-range redirect halts without issuing ----
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'(DEPTH * 4));
    check("range.bubble", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("range.halted", {31'b0, halted}, 32'd1);
      check("range.valid", {31'b0, inst_valid}, 32'd0);
    end

    // ---- reset mid-run at pc=8 ----
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("prereset.pc", pc, 32'h8);
    do_reset(1'b1);
    check("midreset.inst", inst, 32'h0);
    check("midreset.valid", {31'b0, inst_valid}, 32'd0);
    check("midreset.pc", pc, 32'h0);
    check("midreset.halted", {31'b0, halted}, 32'd0);
    check("midreset.state", {30'b0, state_dbg}, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("postreset.pc", pc, 32'h0);
    check("postreset.inst", inst, 32'h5400_0005);

    // ---- randomized run against the model ----
    begin
      logic r_run;
      logic [31:0] tg;
      logic [31:0] dt;
      r_run = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) r_run = ~r_run;
        tg = ($urandom_range(0, 31) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 8));
        dt = ($urandom_range(0, 15) == 0) ? {HALT_OP, 26'($urandom)} : {6'($urandom_range(0, 62)), 26'($urandom)};
        drive(($urandom_range(0, 39) != 0), r_run, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), tg,
              ($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)), dt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
